// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected result collector.
//   fc_state_e : collector FSM states (IDLE is the reset state).
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } fc_state_e;

endpackage : fc_pkg

// File: rtl/fc_result_collector_mem.sv
// Single-port frame buffer with a registered read port.
//   clk   : clock
//   rst_n : async active-low reset (clears the read register only)
//   we    : write enable, din written to mem[addr]
//   addr  : shared read/write address; addresses >= DEPTH read as 0
//   din   : write data
//   dout  : read data, mem[addr] sampled on the previous rising edge
module memory #(
  parameter  int W     = 32,
  parameter  int DEPTH = 13,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  // Addresses past the last word read as zero instead of aliasing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  dout <= '0;
    else if (int'(addr) < DEPTH) dout <= mem[addr];
    else                         dout <= '0;
  end

endmodule : memory

// File: rtl/fc_result_collector.sv
// Collects M signed result words from an fc layer into a frame buffer, tracks
// the running argmax, then holds the frame until the consumer acknowledges it.
//   clk          : clock
//   reset        : async active-low reset
//   input_valid  : upstream word valid
//   input_ready  : high only while collecting
//   input_data   : signed result word
//   frame_valid  : a complete frame is held
//   frame_ack    : consumer releases the held frame (honoured only in HOLD)
//   max_idx      : index of the largest word (lowest index on ties)
//   max_val      : value of the largest word
//   rd_addr      : frame read index (used while holding)
//   rd_data      : buffer[rd_addr], one cycle latency, 0 for rd_addr >= M
//   frame_count  : frames acknowledged since reset, wraps at 2^16
module fc_result_collector
  import fc_pkg::*;
#(
  parameter  int M         = 13,
  parameter  int T         = 32,
  localparam int LOGSIZE_M = $clog2(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic signed [T-1:0]  input_data,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [LOGSIZE_M-1:0] max_idx,
  output logic signed [T-1:0]  max_val,
  input  logic [LOGSIZE_M-1:0] rd_addr,
  output logic signed [T-1:0]  rd_data,
  output logic [15:0]          frame_count
);

  localparam logic [LOGSIZE_M-1:0] LAST_IDX = LOGSIZE_M'(M - 1);

  fc_state_e            state;
  logic [LOGSIZE_M-1:0] wr_cnt;
  logic                 xfer;
  logic [LOGSIZE_M-1:0] mem_addr;
  logic [T-1:0]         mem_dout;

  assign input_ready = (state == COLLECT);
  assign xfer        = input_valid && input_ready;

  // The single buffer port is owned by the writer while collecting and by
  // the consumer's read index otherwise.
  assign mem_addr = (state == COLLECT) ? wr_cnt : rd_addr;
  assign rd_data  = $signed(mem_dout);

  memory #(T, M) u_frame_buf (
    .clk   (clk),
    .rst_n (reset),
    .we    (xfer),
    .addr  (mem_addr),
    .din   (input_data),
    .dout  (mem_dout)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch sees the pre-edge values of state, wr_cnt and max_val.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      frame_valid <= 1'b0;
      max_val     <= '0;
      max_idx     <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: state <= COLLECT;

        COLLECT: begin
          if (xfer) begin
            // Both operands are signed, so this is a signed compare; strict
            // '>' keeps the earlier index on a tie.
            if (wr_cnt == '0 || input_data > max_val) begin
              max_val <= input_data;
              max_idx <= wr_cnt;
            end
            if (wr_cnt == LAST_IDX) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + LOGSIZE_M'(1);
            end
          end
        end

        HOLD: begin
          if (frame_ack) begin
            state       <= COLLECT;
            frame_valid <= 1'b0;
            wr_cnt      <= '0;
            frame_count <= frame_count + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : fc_result_collector

// File: tb/tb_fc_result_collector.sv
// Scoreboard bench for fc_result_collector: a driver issues frames (pushing
// the expected argmax and contents into a queue), a monitor pops and checks
// whenever the collector presents a frame, reads it back and acknowledges it.
module tb_fc_result_collector;

  localparam int M  = 13;
  localparam int T  = 32;
  localparam int AW = $clog2(M);
  localparam int NF = 8;

  logic                 clk;
  logic                 reset;
  logic                 input_valid;
  logic                 input_ready;
  logic signed [T-1:0]  input_data;
  logic                 frame_valid;
  logic                 frame_ack;
  logic [AW-1:0]        max_idx;
  logic signed [T-1:0]  max_val;
  logic [AW-1:0]        rd_addr;
  logic signed [T-1:0]  rd_data;
  logic [15:0]          frame_count;

  fc_result_collector #(.M(M), .T(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .max_idx     (max_idx),
    .max_val     (max_val),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                  idx;
    logic signed [T-1:0] val;
    logic signed [T-1:0] w [M];
    bit                  ack_first;
  } exp_t;

  exp_t                exp_q [$];
  logic signed [T-1:0] frames [NF][M];
  int                  gap_mode  [NF];  // 0: every cycle, 1: every other, 2: random
  bit                  probe     [NF];  // present an extra word during HOLD
  bit                  ack_first [NF];  // acknowledge on the first HOLD cycle
  int                  checks   = 0;
  int                  failures = 0;
  int                  acks     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: largest value first, then the first position holding it.
  function automatic exp_t model(input int f);
    exp_t e;
    e.val = frames[f][0];
    for (int i = 0; i < M; i++) begin
      e.w[i] = frames[f][i];
      if (frames[f][i] > e.val) e.val = frames[f][i];
    end
    e.idx = -1;
    for (int i = M - 1; i >= 0; i--) if (frames[f][i] == e.val) e.idx = i;
    e.ack_first = ack_first[f];
    return e;
  endfunction

  task automatic drive_frame(input int f, input int nwords);
    bit tog = 1'b0;
    if (nwords == M) exp_q.push_back(model(f));
    for (int i = 0; i < nwords; i++) begin
      int cycles = 0;
      forever begin
        bit v;
        @(negedge clk);
        case (gap_mode[f])
          0:       v = 1'b1;
          1:       begin tog = ~tog; v = tog; end
          default: v = 1'($urandom_range(0, 1));
        endcase
        input_valid = v;
        input_data  = v ? frames[f][i] : T'($urandom);
        if (v && input_ready) break;
        if (++cycles > 1000) begin
          check("drive_timeout", 64'(cycles), 64'(0));
          input_valid = 1'b0;
          return;
        end
      end
      if (i == M - 1) check("fv_before_last", 64'(frame_valid), 64'(0));
    end
    @(negedge clk);
    input_valid = 1'b0;
    if (nwords == M) begin
      check("fv_after_last", 64'(frame_valid), 64'(1));
      if (probe[f]) begin
        input_valid = 1'b1;
        input_data  = 32'sh7fff_ffff;
        repeat (3) begin
          check("ready_in_hold", 64'(input_ready), 64'(0));
          @(negedge clk);
        end
        input_valid = 1'b0;
      end
    end
  endtask

  task automatic monitor(input int nframes);
    for (int n = 0; n < nframes; n++) begin
      exp_t e;
      int   cycles = 0;
      forever begin
        @(negedge clk);
        if (frame_valid) break;
        // Acks outside HOLD must be ignored.
        frame_ack = ($urandom_range(0, 3) == 0);
        if (++cycles > 2000) break;
      end
      frame_ack = 1'b0;
      if (!frame_valid) begin
        check("frame_timeout", 64'(frame_valid), 64'(1));
        return;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 64'(exp_q.size()), 64'(1));
        return;
      end
      e = exp_q.pop_front();
      check("max_idx", 64'(max_idx), 64'(e.idx));
      check("max_val", 64'(max_val), 64'(e.val));
      check("count_in_hold", 64'(frame_count), 64'(acks));
      check("ready_first_hold", 64'(input_ready), 64'(0));
      if (!e.ack_first) begin
        logic signed [T-1:0] prev = '0;
        for (int a = 0; a < M + 2; a++) begin
          logic signed [T-1:0] want;
          want    = (a < M) ? e.w[a] : '0;
          rd_addr = AW'(a);
          if (a > 0) begin
            #1;
            check("rd_latency", 64'(rd_data), 64'(prev));
          end
          @(negedge clk);
          check("rd_data", 64'(rd_data), 64'(want));
          prev = want;
        end
        check("max_idx_stable", 64'(max_idx), 64'(e.idx));
        check("max_val_stable", 64'(max_val), 64'(e.val));
        check("fv_stable", 64'(frame_valid), 64'(1));
      end
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      acks++;
      check("ready_after_ack", 64'(input_ready), 64'(1));
      check("fv_after_ack", 64'(frame_valid), 64'(0));
      check("count_after_ack", 64'(frame_count), 64'(16'(acks)));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    input_valid = 1'b0;
    input_data  = '0;
    frame_ack   = 1'b0;
    rd_addr     = '0;

    // Frame contents and per-frame handshake behaviour.
    for (int i = 0; i < M; i++) begin
      frames[0][i] = T'(i);
      frames[1][i] = (i == 3) ? T'(-5) : T'(-9);
      frames[2][i] = (i == 2 || i == 9) ? T'(7) : T'(0);
      frames[3][i] = T'($urandom);
      frames[4][i] = T'(int'($urandom_range(0, 6)) - 3);
      frames[5][i] = T'($urandom);
      frames[6][i] = T'(int'($urandom_range(0, 200)) - 100);
      frames[7][i] = T'($urandom);
    end
    frames[5][$urandom_range(0, M - 1)] = 32'sh8000_0000;
    frames[5][$urandom_range(0, M - 1)] = 32'sh7fff_ffff;
    gap_mode[0] = 0; probe[0] = 1'b1; ack_first[0] = 1'b0;
    gap_mode[1] = 0; probe[1] = 1'b0; ack_first[1] = 1'b1;
    gap_mode[2] = 1; probe[2] = 1'b1; ack_first[2] = 1'b0;
    for (int f = 3; f < NF; f++) begin
      gap_mode[f]  = 2;
      ack_first[f] = 1'($urandom_range(0, 1));
      probe[f]     = !ack_first[f] && 1'($urandom_range(0, 1));
    end

    repeat (3) @(negedge clk);
    check("rst_frame_valid", 64'(frame_valid), 64'(0));
    check("rst_input_ready", 64'(input_ready), 64'(0));
    check("rst_max_val", 64'(max_val), 64'(0));
    check("rst_max_idx", 64'(max_idx), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    reset = 1'b1;
    #1;
    check("ready_in_idle", 64'(input_ready), 64'(0));
    @(negedge clk);
    check("ready_after_idle", 64'(input_ready), 64'(1));

    fork
      begin
        for (int f = 0; f < NF; f++) drive_frame(f, M);
      end
      monitor(NF);
    join
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    // Abandon a frame after 6 transfers, then collect a fresh one.
    drive_frame(5, 6);
    reset = 1'b0;
    #1;
    acks = 0;
    check("rst2_frame_valid", 64'(frame_valid), 64'(0));
    check("rst2_input_ready", 64'(input_ready), 64'(0));
    check("rst2_max_val", 64'(max_val), 64'(0));
    check("rst2_max_idx", 64'(max_idx), 64'(0));
    check("rst2_frame_count", 64'(frame_count), 64'(0));
    check("rst2_rd_data", 64'(rd_data), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    fork
      drive_frame(6, M);
      monitor(1);
    join
    check("queue_drained2", 64'(exp_q.size()), 64'(0));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fc_result_collector

// File: doc/fc_result_collector.md
FC_RESULT_COLLECTOR -- requirements
Module: fc_result_collector

Interface
REQ-001 SHALL have parameter M, default 13: number of result words per frame (fc output rows).
REQ-002 SHALL have parameter T, default 32: signed word width.
REQ-003 SHALL have localparam LOGSIZE_M = $clog2(M), the width of all word-index signals.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port input_valid  input  1  upstream result word valid.
REQ-007 SHALL have port input_ready  output  1  collector accepts a word this cycle.
REQ-008 SHALL have port input_data  input  T  signed result word.
REQ-009 SHALL have port frame_valid  output  1  a complete M-word frame is held.
REQ-010 SHALL have port frame_ack  input  1  consumer releases the held frame.
REQ-011 SHALL have port max_idx  output  LOGSIZE_M  index of the largest word in the frame.
REQ-012 SHALL have port max_val  output  T  signed value of the largest word.
REQ-013 SHALL have port rd_addr  input  LOGSIZE_M  frame read index.
REQ-014 SHALL have port rd_data  output  T  signed frame word at rd_addr.
REQ-015 SHALL have port frame_count  output  16  number of frames acknowledged since reset.

Function
REQ-016 SHALL implement the FSM states IDLE, COLLECT and HOLD, with IDLE as the reset state.
REQ-017 SHALL go from IDLE to COLLECT unconditionally on the first clock edge after reset release.
REQ-018 SHALL drive input_ready = 1 only in COLLECT, combinationally from state; it SHALL be 0 in IDLE and HOLD.
REQ-019 SHALL treat a cycle as a transfer when input_valid && input_ready; input_data SHALL be written to buffer word k, where k is the transfer index 0..M-1.
REQ-020 SHALL, on transfer k=0, load max_val=input_data and max_idx=0.
REQ-021 SHALL, on a later transfer, replace max_val/max_idx only if input_data is strictly greater as a signed comparison; on a tie the lower index SHALL be kept.
REQ-022 SHALL, on transfer k=M-1, move to HOLD; frame_valid SHALL be 1 from the next cycle through the whole of HOLD.
REQ-023 SHALL, in HOLD with frame_ack=1, return to COLLECT next cycle, clear the word counter and increment frame_count (wrapping at 2^16).
REQ-024 SHALL ignore frame_ack outside HOLD.
REQ-025 SHALL ignore input_valid when input_ready=0; no write and no counter change.
REQ-026 SHALL give rd_data a latency of one cycle: buffer[rd_addr] sampled in cycle n appears in n+1.
REQ-027 SHALL hold rd_data defined only in HOLD; in other states rd_data is don't-care.
REQ-028 SHALL return 0 on rd_data for rd_addr >= M.
REQ-029 SHALL hold max_val/max_idx stable throughout HOLD; they SHALL update only on transfers.
REQ-030 SHALL, when frame_ack is asserted on the first HOLD cycle, keep input_ready 0 in that cycle and make it 1 in the next.

Reset
REQ-031 SHALL, while reset=0, force state=IDLE, word counter=0, frame_valid=0, input_ready=0, max_val=0, max_idx=0, frame_count=0 and rd_data=0.
REQ-032 SHALL, on reset asserted mid-frame or mid-HOLD, abandon the partial or held frame with no frame_count increment; buffer contents need not be cleared.

Structure
REQ-033 SHALL take the state enum (IDLE/COLLECT/HOLD) from shared package fc_pkg.
REQ-034 SHALL instantiate the frame buffer as the existing single-port memory sub-module (memory #(T, M), registered read).
REQ-035 SHALL drive the memory address with the write counter in COLLECT and with rd_addr in HOLD.
REQ-036 SHALL keep the FSM, counter, argmax and frame_count in the collector module itself.

Verification
REQ-037 SHALL check: 13 back-to-back words 0..12 -> frame_valid=1 the cycle after word 12, max_idx=12, max_val=12.
REQ-038 SHALL check: words with -5 at index 3 and all others -9 -> max_idx=3, max_val=-5.
REQ-039 SHALL check: values 7 at indices 2 and 9 (others 0) -> max_idx=2.
REQ-040 SHALL check: input_valid toggling every other cycle plus a 14th word presented during HOLD -> 14th word not accepted (input_ready=0), frame unchanged; rd_addr=0..12 returns stored words, one cycle late.
REQ-041 SHALL check: frame_ack on the first HOLD cycle -> input_ready=1 one cycle later; frame_count 0->1; a second frame collects correctly.
REQ-042 SHALL check: reset pulled low after 6 transfers -> all outputs return to reset values; the next frame starts at index 0 with frame_count=0.
